enc8to3_rr: RTL and testbench

Registered 8-to-3 encoder with round-robin arbitration, the inverse of the `dec3to8` one-hot decoder. It takes eight one-hot-convention request lines and produces a held 3-bit index plus the matching one-hot grant under a valid/ready handshake. It sits between the processor's request sources (register/peripheral select lines) and any consumer that needs a binary index, such as the control unit, a bus multiplexer select, or `dec3to8`'s `W` input.

---
 rtl/enc8to3_rr.sv | 129 ++++++++++++
 tb/tb_enc8to3_rr.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/enc8to3_rr.sv
// Registered 8-to-3 encoder with a round-robin pick and a valid/ready hold.
// Define ENC8TO3_RR_EN for rotating priority; without it index 0 (Req[7]) always has priority.
module enc8to3_rr (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic [7:0] Req,
  input  logic       Ready,
  output logic [2:0] W,
  output logic [7:0] Grant,
  output logic       Valid,
  output logic       Multi
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t     state_q, state_d;
  logic [2:0] w_q, w_d;
  logic [7:0] grant_q, grant_d;
  logic       valid_q, valid_d;
  logic       multi_q, multi_d;

  logic [7:0] req_idx;
  logic [7:0] sel_req;
  logic [2:0] sel_start;
  logic [2:0] idle_start;
  logic [2:0] accept_start;
  logic [3:0] pick;
  logic       take;

`ifdef ENC8TO3_RR_EN
  logic [2:0] ptr_q, ptr_d;
  assign idle_start   = ptr_q;
  assign accept_start = w_q + 3'd1;
`else
  assign idle_start   = 3'd0;
  assign accept_start = 3'd0;
`endif

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [3:0] rr_pick(input logic [7:0] vec, input logic [2:0] start);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0;
    for (int k = 7; k >= 0; k--) begin
      idx = start + k[2:0];
      if (vec[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  // Bit i of req_idx is the request for index i (Req[7] is index 0).
  assign req_idx = {<<{Req}};

  always_comb begin
    sel_req   = req_idx;
    sel_start = idle_start;
    if (state_q == HOLD) begin
      sel_req   = req_idx & ~(8'd1 << w_q);
      sel_start = accept_start;
    end
  end

  assign pick = rr_pick(sel_req, sel_start);

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    grant_d = grant_q;
    valid_d = valid_q;
    multi_d = multi_q;
    take    = 1'b0;
`ifdef ENC8TO3_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE:    take = 1'b1;
      HOLD:    take = Ready;
      default: take = 1'b1;
    endcase

    if (take) begin
`ifdef ENC8TO3_RR_EN
      if (state_q == HOLD) ptr_d = accept_start;
`endif
      if (pick[3]) begin
        state_d = HOLD;
        w_d     = pick[2:0];
        grant_d = 8'h80 >> pick[2:0];
        valid_d = 1'b1;
        multi_d = |(sel_req & ~(8'd1 << pick[2:0]));
      end else begin
        state_d = IDLE;
        w_d     = 3'd0;
        grant_d = 8'h00;
        valid_d = 1'b0;
        multi_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= IDLE;
      w_q     <= 3'd0;
      grant_q <= 8'h00;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      multi_q <= multi_d;
    end
  end

`ifdef ENC8TO3_RR_EN
  always_ff @(posedge Clock) begin
    if (!Resetn) ptr_q <= 3'd0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign W     = w_q;
  assign Grant = grant_q;
  assign Valid = valid_q;
  assign Multi = multi_q;

endmodule

// File: tb/tb_enc8to3_rr.sv
// Self-checking bench for enc8to3_rr: hand-written vector table plus a randomized
// phase against a behavioural model, with expectations queued and compared after each edge.
module tb_enc8to3_rr;

`ifdef ENC8TO3_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       Clock;
  logic       Resetn;
  logic [7:0] Req;
  logic       Ready;
  logic [2:0] W;
  logic [7:0] Grant;
  logic       Valid;
  logic       Multi;

  enc8to3_rr dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .Req   (Req),
    .Ready (Ready),
    .W     (W),
    .Grant (Grant),
    .Valid (Valid),
    .Multi (Multi)
  );

  typedef struct {
    logic [2:0] w;
    logic [7:0] grant;
    bit         valid;
    bit         multi;
    string      name;
  } exp_t;

  typedef struct {
    bit         rn;
    logic [7:0] req;
    bit         rdy;
    exp_t       e;
  } vec_t;

  vec_t vecs[$];
  exp_t scoreboard[$];
  int   checks   = 0;
  int   failures = 0;

  // behavioural reference state for the random phase
  bit m_valid;
  int m_w;
  int m_ptr;
  bit m_multi;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic exp_t mkExp(bit v, int w, bit m, string name);
    exp_t e;
    e.valid = v;
    e.w     = v ? 3'(w) : 3'd0;
    e.grant = v ? (8'h80 >> w) : 8'h00;
    e.multi = v ? m : 1'b0;
    e.name  = name;
    return e;
  endfunction

  function automatic void addVec(bit rn, logic [7:0] req, bit rdy, bit v, int w, bit m, string name);
    vec_t x;
    x.rn  = rn;
    x.req = req;
    x.rdy = rdy;
    x.e   = mkExp(v, w, m, name);
    vecs.push_back(x);
  endfunction

  task automatic cmp(string what, string name, logic [7:0] act, logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s.%s actual=%h required=%h @%0t", name, what, act, req, $time);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (scoreboard.size() == 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_empty actual=0 required=1 @%0t", $time);
    end else begin
      e = scoreboard.pop_front();
      cmp("W",     e.name, {5'd0, W},     {5'd0, e.w});
      cmp("Grant", e.name, Grant,         e.grant);
      cmp("Valid", e.name, {7'd0, Valid}, {7'd0, e.valid});
      cmp("Multi", e.name, {7'd0, Multi}, {7'd0, e.multi});
    end
  endtask

  task automatic applyStimulus(bit rn, logic [7:0] req, bit rdy, exp_t e);
    @(negedge Clock);
    Resetn = rn;
    Req    = req;
    Ready  = rdy;
    scoreboard.push_back(e);
    @(posedge Clock);
    #1;
    checkOutput();
  endtask

  // Independent reference: linear scan from the priority pointer, popcount for Multi.
  task automatic modelStep(bit rn, logic [7:0] req, bit rdy, output exp_t e);
    logic [7:0] cand;
    int start, i, win;
    bit hit;
    if (!rn) begin
      m_valid = 0; m_w = 0; m_multi = 0; m_ptr = 0;
    end else if (!m_valid || rdy) begin
      cand = req;
      if (m_valid) begin
        cand[7 - m_w] = 1'b0;
        m_ptr = RR ? (m_w + 1) % 8 : 0;
      end
      start = m_ptr;
      hit = 0; win = 0;
      for (int k = 0; k < 8; k++) begin
        i = (start + k) % 8;
        if (!hit && cand[7 - i]) begin hit = 1; win = i; end
      end
      m_valid = hit;
      m_w     = hit ? win : 0;
      m_multi = hit && ($countones(cand) > 1);
    end
    e = mkExp(m_valid, m_w, m_multi, "random");
  endtask

  initial begin
    exp_t e;
    bit rn, rdy;
    logic [7:0] req;

    Resetn = 1'b0;
    Req    = 8'h00;
    Ready  = 1'b0;

    // reset with requests and ready asserted, then first grant
    addVec(0, 8'hFF, 1, 0, 0, 0, "reset0");
    addVec(0, 8'hFF, 1, 0, 0, 0, "reset1");
    addVec(1, 8'hFF, 0, 1, 0, 1, "first_grant");
    addVec(1, 8'hFF, 0, 1, 0, 1, "hold_ff");
    // sweep with Ready every cycle
    for (int k = 0; k < 8; k++)
      addVec(1, 8'hFF, 1, 1, RR ? (k + 1) % 8 : ((k % 2 == 0) ? 1 : 0), 1, "sweep");
    addVec(0, 8'h00, 0, 0, 0, 0, "reset2");
    // hold stability with the request dropped
    addVec(1, 8'h04, 0, 1, 5, 0, "hold_c0");
    addVec(1, 8'h04, 0, 1, 5, 0, "hold_c1");
    addVec(1, 8'h00, 0, 1, 5, 0, "hold_c2");
    addVec(1, 8'h00, 0, 1, 5, 0, "hold_c3");
    addVec(1, 8'h00, 0, 1, 5, 0, "hold_c4");
    addVec(1, 8'h00, 1, 0, 0, 0, "hold_accept");
    addVec(1, 8'h00, 0, 0, 0, 0, "idle_empty");
    // wrap: accept index 6, then 7 has priority
    addVec(1, 8'h02, 0, 1, 6, 0, "wrap_g6");
    addVec(1, 8'h00, 1, 0, 0, 0, "wrap_acc6");
    addVec(1, 8'h81, 0, 1, RR ? 7 : 0, 1, "wrap_first");
    addVec(1, 8'h81, 1, 1, RR ? 0 : 7, 0, "wrap_second");
    addVec(1, 8'h00, 1, 0, 0, 0, "wrap_done");
    // reset in the middle of a held grant
    addVec(1, 8'h10, 0, 1, 3, 0, "mid_grant");
    addVec(0, 8'h10, 1, 0, 0, 0, "mid_reset");
    addVec(1, 8'hFF, 0, 1, 0, 1, "mid_after");
    addVec(0, 8'h00, 0, 0, 0, 0, "reset3");
    // single request, Ready high throughout
    addVec(1, 8'h10, 1, 1, 3, 0, "single_g");
    addVec(1, 8'h10, 1, 0, 0, 0, "single_gap");
    addVec(1, 8'h10, 1, 1, 3, 0, "single_again");
    addVec(1, 8'h00, 1, 0, 0, 0, "single_done");

    for (int n = 0; n < vecs.size(); n++)
      applyStimulus(vecs[n].rn, vecs[n].req, vecs[n].rdy, vecs[n].e);

    // randomized phase, starting from reset so the model is aligned
    modelStep(0, 8'h00, 0, e);
    applyStimulus(0, 8'h00, 0, e);
    for (int n = 0; n < 400; n++) begin
      rn  = ($urandom_range(0, 40) != 0);
      rdy = $urandom_range(0, 1) == 1;
      req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      modelStep(rn, req, rdy, e);
      applyStimulus(rn, req, rdy, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
